// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes and
// multi-cycle memory holds (PC push/pop) with a stall-cycle counter.
module hazard_sequencer #(
  parameter int MULTI_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rsrc,
  input  logic [2:0]  id_rdest,
  input  logic        id_uses_rsrc,
  input  logic        id_uses_rdest,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [2:0]  ex_rdest,
  input  logic        ex_branch_taken,
  input  logic        ex_multi_mem,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_hold,
  output logic        state,
  output logic [15:0] stall_count
);

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic        load_use;

  // Load-use detect; an unknown compare takes the else path (no match)
  always_comb begin
    load_use = 1'b0;
    if (ex_mem_read && ex_reg_write) begin
      if (id_uses_rsrc && (ex_rdest == id_rsrc))
        load_use = 1'b1;
      else if (id_uses_rdest && (ex_rdest == id_rdest))
        load_use = 1'b1;
    end
  end

  // Next state, hold counter and pipeline control outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_hold = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_multi_mem || load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
        if (ex_multi_mem) begin
          ex_mem_hold = 1'b1;
          id_ex_flush = 1'b1;
          cnt_d       = 2'(MULTI_CYCLES - 1);
          state_d     = MULTI;
        end
      end
      MULTI: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        ex_mem_hold = 1'b1;
        if (cnt_q == 2'd0)
          state_d = RUN;
        else
          cnt_d = cnt_q - 2'd1;
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_hold = 1'b0;
    end
  end

  // Saturating count of cycles in which the PC is frozen
  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_write && stall_count_q != 16'hFFFF)
      stall_count_d = stall_count_q + 16'd1;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= 2'd0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: a cycle-level reference
// model pushes expected outputs, a negedge monitor pops and compares.
module tb_hazard_sequencer;

  localparam int MC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  id_rsrc = '0, id_rdest = '0, ex_rdest = '0;
  logic        id_uses_rsrc = 0, id_uses_rdest = 0;
  logic        ex_mem_read = 0, ex_reg_write = 0;
  logic        ex_branch_taken = 0, ex_multi_mem = 0;
  logic        pc_write, if_id_write, if_id_flush;
  logic        id_ex_flush, ex_mem_hold, state;
  logic [15:0] stall_count;

  hazard_sequencer #(.MULTI_CYCLES(MC)) dut (
    .clk(clk), .rst(rst),
    .id_rsrc(id_rsrc), .id_rdest(id_rdest),
    .id_uses_rsrc(id_uses_rsrc), .id_uses_rdest(id_uses_rdest),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rdest(ex_rdest), .ex_branch_taken(ex_branch_taken),
    .ex_multi_mem(ex_multi_mem),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_hold(ex_mem_hold), .state(state),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold}
  typedef struct {
    logic [4:0]  ctl;
    logic        st;
    logic [15:0] sc;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;

  // model: rem = MULTI cycles still to come, sc = stall cycles so far
  int rem = 0;
  int sc = 0;

  task automatic cyc(input logic r, input logic [2:0] rs, input logic [2:0] rd,
                     input logic urs, input logic urd, input logic mr,
                     input logic rw, input logic [2:0] exd, input logic br,
                     input logic mm);
    exp_t e;
    bit lu;
    rst = r; id_rsrc = rs; id_rdest = rd;
    id_uses_rsrc = urs; id_uses_rdest = urd;
    ex_mem_read = mr; ex_reg_write = rw; ex_rdest = exd;
    ex_branch_taken = br; ex_multi_mem = mm;
    lu = mr && rw && ((urs && exd == rs) || (urd && exd == rd));
    e.st = (rem > 0);
    e.sc = 16'(sc);
    e.cyc = cyc_no;
    if (r) begin
      e.ctl = 5'b00110;
      rem = 0;
      sc = 0;
    end else begin
      if (rem > 0) begin
        e.ctl = 5'b00011;
        rem = rem - 1;
      end else if (br) begin
        e.ctl = {4'b1111, mm};
        rem = mm ? MC : 0;
      end else if (mm) begin
        e.ctl = 5'b00011;
        rem = MC;
      end else if (lu) begin
        e.ctl = 5'b00010;
      end else begin
        e.ctl = 5'b11000;
      end
      if (!e.ctl[4] && sc < 65535) sc = sc + 1;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: outputs are valid every cycle once the first entry exists
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if ({pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold} !== e.ctl
            || state !== e.st || stall_count !== e.sc) begin
          n_bad++;
          $display("FAIL cyc%0d ctl/state/cnt got %b/%b/%h want %b/%b/%h",
                   e.cyc,
                   {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold},
                   state, stall_count, e.ctl, e.st, e.sc);
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    idle();
    // load-use on rsrc, then on rdest
    cyc(0, 3, 0, 1, 0, 1, 1, 3, 0, 0);
    idle();
    cyc(0, 1, 5, 0, 1, 1, 1, 5, 0, 0);
    idle();
    // same operands but not read
    cyc(0, 3, 3, 0, 0, 1, 1, 3, 0, 0);
    // branch overrides load-use
    cyc(0, 3, 0, 1, 0, 1, 1, 3, 1, 0);
    idle();
    // multi op
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (4) idle();
    // CALL, with branch/multi still raised during MULTI
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 2, 0, 1, 0, 1, 1, 2, 1, 1);
    repeat (3) idle();
    // reset on second MULTI cycle
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) idle();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 40) == 0),
          3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          3'($urandom_range(0, 3)),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
    end
    // saturation: continuous load-use drives the count past FFFF
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++)
      cyc(0, 4, 0, 1, 0, 1, 1, 4, 0, 0);
    idle();
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left %0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
